gpr_wb_arbiter: RTL

- Shares the single GPR write port between two writeback sources: A (ALU/CSR result path) and B (load-return path from LSU/WBU).
- Arbitrates round-robin and registers the winning write into a one-entry output stage with back-pressure from the register file.
- Keeps a pending-destination scoreboard so the decoder can stall on RAW/WAW hazards.
- Sits between the execute/LSU writeback stages and the GPR file.

---
 rtl/gpr_wb_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/gpr_wb_arbiter.sv
// Round-robin arbiter for the shared GPR write port, with pending-write scoreboard.
// Optional result forwarding from the output stage under GPR_WB_BYPASS_EN.
module gpr_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RAW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [RAW-1:0]  a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [RAW-1:0]  b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            gpr_wen,
  output logic [RAW-1:0]  gpr_waddr,
  output logic [XLEN-1:0] gpr_wdata,
  input  logic            gpr_ready,
  input  logic            iss_valid,
  input  logic [RAW-1:0]  iss_rd,
  input  logic [RAW-1:0]  q_rs1,
  input  logic [RAW-1:0]  q_rs2,
  input  logic [RAW-1:0]  q_rd,
  output logic            hazard
`ifdef GPR_WB_BYPASS_EN
  ,
  output logic            fwd1_valid,
  output logic [XLEN-1:0] fwd1_data,
  output logic            fwd2_valid,
  output logic [XLEN-1:0] fwd2_data
`endif
);

  logic            rr_b;
  logic [NREG-1:0] pend;
  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;
  logic            free;
  logic            gnt_a;
  logic            gnt_b;
  logic            win_nz;
  logic [RAW-1:0]  win_rd;
  logic [XLEN-1:0] win_data;
  logic            hz1;
  logic            hz2;

  // rr_b set means B wins the next contested cycle
  assign free  = !gpr_wen || gpr_ready;
  assign gnt_a = !rst && free && a_valid && (!b_valid || !rr_b);
  assign gnt_b = !rst && free && b_valid && (!a_valid || rr_b);

  assign a_ready  = gnt_a;
  assign b_ready  = gnt_b;
  assign win_rd   = gnt_b ? b_rd : a_rd;
  assign win_data = gnt_b ? b_data : a_data;
  assign win_nz   = (gnt_a || gnt_b) && (win_rd != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpr_wen   <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
      rr_b      <= 1'b0;
    end else begin
      if (gnt_a)
        rr_b <= 1'b1;
      else if (gnt_b)
        rr_b <= 1'b0;
      if (free)
        gpr_wen <= win_nz;
      if (win_nz) begin
        gpr_waddr <= win_rd;
        gpr_wdata <= win_data;
      end
    end
  end

  always_comb begin
    clr = '0;
    set = '0;
    if (gpr_wen && gpr_ready)
      clr[gpr_waddr] = 1'b1;
    if (iss_valid && iss_rd != '0)
      set[iss_rd] = 1'b1;
  end

  // set is applied after clear so a same-cycle issue keeps the bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pend <= '0;
    else
      pend <= ((pend & ~clr) | set) & {{(NREG-1){1'b1}}, 1'b0};
  end

`ifdef GPR_WB_BYPASS_EN
  logic wr_fire;
  assign wr_fire    = gpr_wen && gpr_ready && gpr_waddr != '0;
  assign fwd1_valid = wr_fire && gpr_waddr == q_rs1;
  assign fwd2_valid = wr_fire && gpr_waddr == q_rs2;
  assign fwd1_data  = gpr_wdata;
  assign fwd2_data  = gpr_wdata;
  assign hz1        = pend[q_rs1] && !fwd1_valid;
  assign hz2        = pend[q_rs2] && !fwd2_valid;
`else
  assign hz1 = pend[q_rs1];
  assign hz2 = pend[q_rs2];
`endif

  assign hazard = !rst && (hz1 || hz2 || pend[q_rd]);

endmodule
